// File: rtl/vga_timing_recover.sv
// Recovers pixel coordinates, data-enable, line/frame totals and lock from active-low VGA syncs.
// Optional macro VGA_RX_SYNC2FF_EN inserts a two-flop synchronizer on hsync_in/vsync_in.
module vga_timing_recover #(
  parameter int unsigned H_SYNC2ACT = 142,
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_SYNC2ACT = 35,
  parameter int unsigned V_ACTIVE   = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic       hsync_in,
  input  logic       vsync_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       de,
  output logic       frame_start,
  output logic [9:0] htotal,
  output logic [9:0] vtotal,
  output logic       locked
);

  localparam logic [10:0] H_LO = 11'(H_SYNC2ACT);
  localparam logic [10:0] H_HI = 11'(H_SYNC2ACT + H_ACTIVE);
  localparam logic [10:0] V_LO = 11'(V_SYNC2ACT);
  localparam logic [10:0] V_HI = 11'(V_SYNC2ACT + V_ACTIVE);

  logic hs_s, vs_s;

`ifdef VGA_RX_SYNC2FF_EN
  logic [1:0] hs_sync_q, vs_sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_sync_q <= '1;
      vs_sync_q <= '1;
    end else begin
      hs_sync_q <= {hs_sync_q[0], hsync_in};
      vs_sync_q <= {vs_sync_q[0], vsync_in};
    end
  end

  assign hs_s = hs_sync_q[1];
  assign vs_s = vs_sync_q[1];
`else
  assign hs_s = hsync_in;
  assign vs_s = vsync_in;
`endif

  logic       hs_prev_q, hs_prev_d, vs_prev_q, vs_prev_d, vs_pend_q, vs_pend_d;
  logic [9:0] hpix_q, hpix_d, vline_q, vline_d;
  logic [9:0] htotal_q, htotal_d, vtotal_q, vtotal_d;
  logic       h_ok_q, h_ok_d, v_ok_q, v_ok_d, locked_q, locked_d;
  logic       de_q, de_d, fs_q, fs_d;
  logic [9:0] x_q, x_d, y_q, y_d;

  logic       hs_fall, vs_fall, origin, h_in, v_in;
  logic [9:0] hpix_inc, vline_inc;

  assign hs_fall   = pix_en & hs_prev_q & ~hs_s;
  assign vs_fall   = pix_en & vs_prev_q & ~vs_s;
  assign origin    = hs_fall & (vs_pend_q | vs_fall);
  assign hpix_inc  = hpix_q + 10'd1;
  assign vline_inc = vline_q + 10'd1;
  assign h_in      = ({1'b0, hpix_q} >= H_LO) && ({1'b0, hpix_q} < H_HI);
  assign v_in      = ({1'b0, vline_q} >= V_LO) && ({1'b0, vline_q} < V_HI);

  always_comb begin
    hs_prev_d = hs_prev_q;
    vs_prev_d = vs_prev_q;
    vs_pend_d = vs_pend_q;
    hpix_d    = hpix_q;
    vline_d   = vline_q;
    htotal_d  = htotal_q;
    vtotal_d  = vtotal_q;
    h_ok_d    = h_ok_q;
    v_ok_d    = v_ok_q;
    locked_d  = locked_q;
    fs_d      = 1'b0;
    if (pix_en) begin
      hs_prev_d = hs_s;
      vs_prev_d = vs_s;
      if (hs_fall) begin
        hpix_d    = '0;
        htotal_d  = hpix_inc;
        h_ok_d    = (hpix_inc == htotal_q);
        vs_pend_d = 1'b0;
        // Lock may only rise at the vertical origin; any line mismatch drops it at once.
        if (origin) begin
          vline_d  = '0;
          vtotal_d = vline_inc;
          v_ok_d   = (vline_inc == vtotal_q);
          fs_d     = 1'b1;
          locked_d = h_ok_d & v_ok_d;
        end else begin
          vline_d  = (vline_q == '1) ? vline_q : vline_inc;
          locked_d = locked_q & h_ok_d;
        end
      end else begin
        if (vs_fall) vs_pend_d = 1'b1;
        if (hpix_q != '1) hpix_d = hpix_inc;
        if (hpix_d == '1) begin
          h_ok_d   = 1'b0;
          v_ok_d   = 1'b0;
          locked_d = 1'b0;
        end
      end
    end
    de_d = locked_q & h_in & v_in;
    x_d  = de_d ? (hpix_q - 10'(H_SYNC2ACT)) : '0;
    y_d  = de_d ? (vline_q - 10'(V_SYNC2ACT)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      vs_pend_q <= 1'b0;
      hpix_q    <= '0;
      vline_q   <= '0;
      htotal_q  <= '0;
      vtotal_q  <= '0;
      h_ok_q    <= 1'b0;
      v_ok_q    <= 1'b0;
      locked_q  <= 1'b0;
      de_q      <= 1'b0;
      fs_q      <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      hs_prev_q <= hs_prev_d;
      vs_prev_q <= vs_prev_d;
      vs_pend_q <= vs_pend_d;
      hpix_q    <= hpix_d;
      vline_q   <= vline_d;
      htotal_q  <= htotal_d;
      vtotal_q  <= vtotal_d;
      h_ok_q    <= h_ok_d;
      v_ok_q    <= v_ok_d;
      locked_q  <= locked_d;
      de_q      <= de_d;
      fs_q      <= fs_d;
      x_q       <= x_d;
      y_q       <= y_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign frame_start = fs_q;
  assign htotal      = htotal_q;
  assign vtotal      = vtotal_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_vga_timing_recover.sv
// Directed bench for vga_timing_recover using a scaled-down raster (40 px lines, 12-line frames).
module tb_vga_timing_recover;

  localparam int HS2A  = 8;
  localparam int HACT  = 24;
  localparam int VS2A  = 3;
  localparam int VACT  = 6;
  localparam int LINE  = 40;
  localparam int LINES = 12;
  localparam int HSW   = 6;
`ifdef VGA_RX_SYNC2FF_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic       hsync_in = 1'b1;
  logic       vsync_in = 1'b1;
  logic [9:0] x, y, htotal, vtotal;
  logic       de, frame_start, locked;

  int checks = 0;
  int errors = 0;
  int fs_cnt = 0;
  int de_cnt, bad_cnt, first_x, first_y, last_x, last_y;
  bit seen_de;
  logic [9:0] snap_ht, snap_vt, frame_ht0;
  logic       snap_lk, snap_lk_mid, frame_lk0;

  vga_timing_recover #(
    .H_SYNC2ACT(HS2A),
    .H_ACTIVE  (HACT),
    .V_SYNC2ACT(VS2A),
    .V_ACTIVE  (VACT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_en     (pix_en),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .x          (x),
    .y          (y),
    .de         (de),
    .frame_start(frame_start),
    .htotal     (htotal),
    .vtotal     (vtotal),
    .locked     (locked)
  );

  always #10 clk = ~clk;

  always @(negedge clk) if (frame_start === 1'b1) fs_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_pixel(input logic h, input logic v);
    pix_en   = 1'b1;
    hsync_in = h;
    vsync_in = v;
    @(posedge clk); #1;
    pix_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic send_line(input int len, input bit vlow, input int l, input bit chk);
    for (int p = 0; p < len; p++) begin
      int q;
      bit exp_de;
      drive_pixel(p >= HSW, !vlow);
      if (p == 1) begin
        snap_ht = htotal;
        snap_vt = vtotal;
        snap_lk = locked;
      end
      if (p == 1000) snap_lk_mid = locked;
      if (chk) begin
        q      = p - LAG;
        exp_de = (q >= HS2A) && (q < HS2A + HACT) && (l >= VS2A) && (l < VS2A + VACT);
        if (de !== exp_de) bad_cnt++;
        else if (exp_de && (int'(x) != q - HS2A || int'(y) != l - VS2A)) bad_cnt++;
        else if (!exp_de && (x !== 10'd0 || y !== 10'd0)) bad_cnt++;
        if (de === 1'b1) begin
          de_cnt++;
          if (!seen_de) begin
            first_x = int'(x);
            first_y = int'(y);
            seen_de = 1'b1;
          end
          last_x = int'(x);
          last_y = int'(y);
        end
      end
    end
  endtask

  task automatic send_frame(input bit chk, input int long_l, input int long_len);
    int fs0;
    fs0     = fs_cnt;
    de_cnt  = 0;
    bad_cnt = 0;
    seen_de = 1'b0;
    for (int l = 0; l < LINES; l++) begin
      send_line((l == long_l) ? long_len : LINE, l < 2, l, chk);
      if (l == 0) begin
        frame_lk0 = snap_lk;
        frame_ht0 = snap_ht;
      end
      if (l == long_l + 1) begin
        check("htotal_long", snap_ht, long_len);
        check("lock_drop_long", snap_lk, 0);
      end
      if (l == long_l + 2) begin
        check("htotal_back", snap_ht, LINE);
        check("lock_after_mismatch", snap_lk, 0);
      end
      if (l == long_l + 3) check("lock_waits_origin", snap_lk, 0);
    end
    check("fs_per_frame", fs_cnt - fs0, 1);
    if (chk) begin
      check("de_count", de_cnt, HACT * VACT);
      check("de_pattern_err", bad_cnt, 0);
      check("first_x", first_x, 0);
      check("first_y", first_y, 0);
      check("last_x", last_x, HACT - 1);
      check("last_y", last_y, VACT - 1);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_de", de, 0);
    check("rst_fs", frame_start, 0);
    check("rst_htotal", htotal, 0);
    check("rst_vtotal", vtotal, 0);
    check("rst_locked", locked, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frames 1-2: measurement only, no lock yet
    send_frame(1'b0, 100, 0);
    check("f1_vtotal", vtotal, 1);
    check("f1_locked", locked, 0);
    send_frame(1'b0, 100, 0);
    check("f2_htotal", htotal, LINE);
    check("f2_vtotal", vtotal, LINES);
    check("f2_locked", locked, 0);

    // Frame 3: lock rises at origin, full raster check
    send_frame(1'b1, 100, 0);
    check("f3_lock_origin", frame_lk0, 1);
    check("f3_vtotal", vtotal, LINES);

    // Frame 4: line 4 is 50 px long
    send_frame(1'b0, 4, 50);
    check("f4_locked", locked, 0);
    check("f4_vtotal", vtotal, LINES);

    // Frame 5: relock at origin
    send_frame(1'b1, 100, 0);
    check("f5_lock_origin", frame_lk0, 1);

    // hsync held high: timeout at hpix saturation
    send_line(1100, 1'b0, 0, 1'b0);
    check("to_locked_before_sat", snap_lk_mid, 1);
    check("to_locked", locked, 0);
    check("to_de", de, 0);

    send_frame(1'b0, 100, 0);
    check("toA_htotal_trunc", frame_ht0, 0);
    check("toA_vtotal", vtotal, LINES + 1);
    check("toA_locked", locked, 0);
    send_frame(1'b0, 100, 0);
    check("toB_vtotal", vtotal, LINES);
    check("toB_locked", locked, 0);
    send_frame(1'b1, 100, 0);
    check("toC_lock_origin", frame_lk0, 1);
    check("toC_locked", locked, 1);

    // Asynchronous reset mid-line
    send_line(20, 1'b0, 0, 1'b0);
    #3 rst = 1'b1;
    #1;
    check("arst_x", x, 0);
    check("arst_y", y, 0);
    check("arst_de", de, 0);
    check("arst_fs", frame_start, 0);
    check("arst_htotal", htotal, 0);
    check("arst_vtotal", vtotal, 0);
    check("arst_locked", locked, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_recover.md
Name: vga_timing_recover

Overview:
- Receive-side counterpart of the VGA sync generator: accepts hsync/vsync (active low) plus the pixel-rate strobe and recovers pixel coordinates and a data-enable.
- Measures line length and frame height, and reports lock when timing is stable.
- Sits in front of capture/overlay logic that consumes a VGA-timed stream inside the same 50 MHz clock domain.

Parameters:
- H_SYNC2ACT, 142, pixel count from the hsync falling edge to the first active pixel.
- H_ACTIVE, 640, active pixels per line.
- V_SYNC2ACT, 35, vline value during the first active row.
- V_ACTIVE, 480, active rows per frame.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  reset; asynchronous, active-high.
- pix_en  in  1  pixel strobe, one clk in two (25 MHz rate).
- hsync_in  in  1  horizontal sync, active low, synchronous to clk.
- vsync_in  in  1  vertical sync, active low, synchronous to clk.
- x  out  10  active pixel column.
- y  out  10  active row.
- de  out  1  active video.
- frame_start  out  1  one-clk pulse at vertical origin.
- htotal  out  10  last measured pixels per line.
- vtotal  out  10  last measured lines per frame.
- locked  out  1  timing stable.

Behaviour:
- Reset: every register and output is 0. hs_prev and vs_prev reset to 1.
- Sampling: hsync/vsync are sampled only on clk edges where pix_en=1. Nothing changes on other edges, except that frame_start is cleared.
- Edge detect:
  - hs_fall = pix_en & hs_prev & ~hsync_in.
  - vs_fall = pix_en & vs_prev & ~vsync_in.
- vs_pend: set on vs_fall; cleared on the next hs_fall. If vs_fall and hs_fall occur on the same edge, that hs_fall consumes it.
- hpix counter, updated on pix_en:
  - hs_fall: capture htotal <= hpix+1 (10-bit truncate), then hpix <= 0.
  - Otherwise hpix+1, saturating at 1023.
- vline counter, updated on hs_fall:
  - If vs_pend (or vs_fall on the same edge): vtotal <= vline+1, vline <= 0, frame_start=1 for one clk.
  - Otherwise vline+1, saturating at 1023.
- Timeout: hpix reaching 1023 clears h_ok, v_ok and locked. Counters hold at saturation until the next hs_fall.
- Lock:
  - h_ok = new htotal equals previous htotal; re-evaluated at each hs_fall.
  - v_ok = new vtotal equals previous vtotal; re-evaluated at each vertical origin.
  - locked = h_ok & v_ok, registered.
  - A mismatch drops locked on the same edge that captures the mismatching value.
  - First capture after reset compares against 0, so it never matches.
- Outputs (registered; 1 clk after the pix_en edge that produced the counter values):
  - de = locked & (H_SYNC2ACT <= hpix < H_SYNC2ACT+H_ACTIVE) & (V_SYNC2ACT <= vline < V_SYNC2ACT+V_ACTIVE).
  - x = hpix-H_SYNC2ACT and y = vline-V_SYNC2ACT when de=1; x=0 and y=0 when de=0.
- Arithmetic: all compares use 11-bit widening so that boundary sums do not wrap.
- Reset mid-frame:
  - Immediate clear.
  - Relock needs two full frames after the first vsync falling edge seen after reset.

Optional Feature:
- Macro VGA_RX_SYNC2FF_EN.
- Defined: hsync_in and vsync_in each pass through a two-stage clk synchronizer (reset value 1) before edge detection, for asynchronous external sync sources. All output timing shifts +2 clk; counts are unchanged.
- Undefined: inputs are used directly; latency is as stated above.

Test Plan:
- Stimulus: 790-pixel lines (hsync low 94 px) and 524-line frames (vsync low 2 lines, falling at line start). Response: htotal=790 and vtotal=524. locked rises at the vertical origin of the 3rd vsync after reset, i.e. after two vtotal captures following the first origin.
- Locked frame: de high exactly 640 consecutive pix_en per row over 480 rows. The first de has x=0,y=0 with hpix=142, vline=35. The last de has x=639,y=479. frame_start gives one pulse per frame.
- Hold hsync_in high for 1100 pixels → locked=0 and de=0 once hpix=1023. Restore the nominal stream → relock after two frames.
- Change one line to 800 pixels → htotal=800 and locked=0 on that hs_fall. Two equal-length lines later h_ok returns; locked returns at the frame origin with matching vtotal.
- vsync and hsync fall on the same pix_en edge → vline=0 and frame_start pulses on that edge. Assert rst mid-line → all outputs 0 asynchronously.
- With VGA_RX_SYNC2FF_EN defined → same counts as the first two tests, with de/x/y delayed by exactly 2 clk.
